// File: rtl/i2s_rx.sv
// I2S master receiver: generates bclk/ws from the system clock and deserializes
// one 32-bit slot per frame from the microphone, after an optional warm-up.
module i2s_rx #(
  parameter int CLK_DIV        = 8,
  parameter int STARTUP_FRAMES = 4,
  parameter int CHANNEL        = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sd,
  output logic        bclk,
  output logic        ws,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  output logic        active
);

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int FW = (STARTUP_FRAMES < 2) ? 1 : $clog2(STARTUP_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [FW-1:0] frame_cnt;
  logic [31:0]   shift;
  logic          word_ok;

  logic          div_wrap;
  logic          fall;
  logic [5:0]    next_bit;
  logic [5:0]    win;

  assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
  assign fall     = (state != IDLE) && bclk && div_wrap;
  assign next_bit = bit_cnt + 6'd1;
  // Window index: one-bit I2S delay after ws, offset by 32 for the right slot.
  assign win      = bit_cnt - 6'd1 - 6'(32 * CHANNEL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      bclk         <= 1'b0;
      ws           <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      active       <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_cnt    <= '0;
      shift        <= '0;
      word_ok      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        bclk      <= 1'b0;
        ws        <= 1'b0;
        active    <= 1'b0;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        shift     <= '0;
        word_ok   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (STARTUP_FRAMES == 0) begin
              state  <= RUN;
              active <= 1'b1;
            end else begin
              state <= WARMUP;
            end
          end
          default: begin
            if (div_wrap) begin
              div_cnt <= '0;
              bclk    <= ~bclk;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
            if (fall) begin
              bit_cnt <= next_bit;
              ws      <= next_bit[5];
              if (!win[5]) begin
                shift <= {shift[30:0], sd};
                if (win == 6'd0) word_ok <= (state == RUN);
                // A word only counts if its MSB was also taken while running.
                if (win == 6'd31 && word_ok && state == RUN) begin
                  sample_out   <= {shift[30:0], sd};
                  sample_valid <= 1'b1;
                end
              end
              if (bit_cnt == 6'd63) begin
                if (frame_cnt != FW'(STARTUP_FRAMES)) frame_cnt <= frame_cnt + FW'(1);
                if (state == WARMUP && frame_cnt == FW'(STARTUP_FRAMES - 1)) begin
                  state  <= RUN;
                  active <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: three instances (left, right, no warm-up) with
// an I2S microphone model each, checked at hand-computed cycle offsets.
module tb_i2s_rx;

  localparam logic [31:0] LEFT_WORD  = 32'hA5A55A5A;
  localparam logic [31:0] RIGHT_WORD = 32'h12345678;

  logic        clk = 1'b0;
  logic [2:0]  en;
  logic [2:0]  rst;
  logic [2:0]  bclk_v;
  logic [2:0]  ws_v;
  logic [2:0]  valid_v;
  logic [2:0]  active_v;
  logic [2:0]  sd_v;
  logic [31:0] so_v [3];
  logic        sd_hi;
  int          pulses [3];
  int          cyc;
  int          n0;
  int          base;
  int          checks;
  int          fails;

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SF = (g == 2) ? 0 : 1;
    localparam int CH = (g == 1) ? 1 : 0;

    logic        mic_sd;
    logic        prev_b;
    logic        prev_ws;
    logic        cur_ch;
    logic [31:0] word;
    int          idx;

    i2s_rx #(.CLK_DIV(2), .STARTUP_FRAMES(SF), .CHANNEL(CH)) u_dut (
      .clk         (clk),
      .reset       (rst[g]),
      .enable      (en[g]),
      .sd          (sd_v[g]),
      .bclk        (bclk_v[g]),
      .ws          (ws_v[g]),
      .sample_out  (so_v[g]),
      .sample_valid(valid_v[g]),
      .active      (active_v[g])
    );

    assign sd_v[g] = sd_hi | mic_sd;

    // Microphone: shifts a new bit out after each bclk fall; the MSB of a
    // channel follows one bclk after ws changes, as I2S requires.
    always @(negedge clk) begin
      if (!rst[g] || !en[g]) begin
        mic_sd  = 1'b0;
        prev_b  = 1'b0;
        prev_ws = 1'b0;
        cur_ch  = 1'b0;
        idx     = 0;
      end else begin
        if (prev_b && !bclk_v[g]) begin
          word   = cur_ch ? RIGHT_WORD : LEFT_WORD;
          mic_sd = (idx < 32) ? word[31-idx] : 1'b0;
          idx++;
          if (ws_v[g] != prev_ws) begin
            cur_ch  = ws_v[g];
            prev_ws = ws_v[g];
            idx     = 0;
          end
        end
        prev_b = bclk_v[g];
      end
    end

    initial pulses[g] = 0;
    always @(negedge clk) if (valid_v[g]) pulses[g]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait until just after the negedge that follows edge t (t=0 is the enable edge).
  task automatic to(input int t);
    while (cyc < n0 + t + 1) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    n0     = 0;
    en     = 3'b111;
    rst    = 3'b000;
    sd_hi  = 1'b1;
    idle(5);
    check("rst_bclk",   {31'd0, bclk_v[0]},   32'd0);
    check("rst_ws",     {31'd0, ws_v[0]},     32'd0);
    check("rst_valid",  {31'd0, valid_v[0]},  32'd0);
    check("rst_active", {29'd0, active_v},    32'd0);
    check("rst_out",    so_v[0],              32'd0);

    en    = 3'b000;
    rst   = 3'b111;
    sd_hi = 1'b0;
    idle(5);
    check("rel_active", {29'd0, active_v}, 32'd0);
    check("rel_bclk",   {29'd0, bclk_v},   32'd0);
    check("rel_out",    so_v[0],           32'd0);

    en = 3'b111;
    n0 = cyc;
    to(0);
    check("t0_active_warm",  {31'd0, active_v[0]}, 32'd0);
    check("t0_active_nowarm",{31'd0, active_v[2]}, 32'd1);
    to(1);
    check("bclk_t1", {31'd0, bclk_v[0]}, 32'd0);
    to(2);
    check("bclk_t2", {31'd0, bclk_v[0]}, 32'd1);
    to(4);
    check("bclk_t4", {31'd0, bclk_v[0]}, 32'd0);
    to(127);
    check("ws_t127", {31'd0, ws_v[0]}, 32'd0);
    to(128);
    check("ws_t128", {31'd0, ws_v[0]}, 32'd1);
    to(131);
    check("nowarm_nopulse", pulses[2], 0);
    to(132);
    check("nowarm_valid", {31'd0, valid_v[2]}, 32'd1);
    check("nowarm_word",  so_v[2],             LEFT_WORD);
    to(255);
    check("ws_t255",     {31'd0, ws_v[0]},     32'd1);
    check("warm_active", {31'd0, active_v[0]}, 32'd0);
    to(256);
    check("ws_t256",     {31'd0, ws_v[0]},     32'd0);
    check("run_active",  {31'd0, active_v[0]}, 32'd1);
    to(260);
    check("right_straddle_valid", {31'd0, valid_v[1]}, 32'd0);
    check("right_straddle_cnt",   pulses[1], 0);
    to(387);
    check("left_nopulse_early", pulses[0], 0);
    to(388);
    check("left_valid", {31'd0, valid_v[0]}, 32'd1);
    check("left_word",  so_v[0],             LEFT_WORD);
    to(389);
    check("left_pulse_width", {31'd0, valid_v[0]}, 32'd0);
    check("left_hold",        so_v[0],             LEFT_WORD);
    to(515);
    check("right_nopulse_early", pulses[1], 0);
    to(516);
    check("right_valid", {31'd0, valid_v[1]}, 32'd1);
    check("right_word",  so_v[1],             RIGHT_WORD);
    to(643);
    check("left_one_pulse", pulses[0], 1);
    to(644);
    check("left_valid2", {31'd0, valid_v[0]}, 32'd1);
    check("left_cnt2",   pulses[0], 2);

    en = 3'b000;
    idle(6);
    en[0] = 1'b1;
    n0    = cyc;
    base  = pulses[0];
    to(299);
    en[0] = 1'b0;
    to(300);
    check("drop_bclk",   {31'd0, bclk_v[0]},   32'd0);
    check("drop_ws",     {31'd0, ws_v[0]},     32'd0);
    check("drop_active", {31'd0, active_v[0]}, 32'd0);
    check("drop_valid",  {31'd0, valid_v[0]},  32'd0);
    check("drop_out",    so_v[0],              LEFT_WORD);
    to(420);
    check("drop_nopulse", pulses[0] - base, 0);

    en[0] = 1'b1;
    n0    = cyc;
    base  = pulses[0];
    to(387);
    check("reen_nopulse_early", pulses[0] - base, 0);
    to(388);
    check("reen_valid", {31'd0, valid_v[0]}, 32'd1);
    check("reen_word",  so_v[0],             LEFT_WORD);

    en[0] = 1'b0;
    idle(6);
    en[0] = 1'b1;
    n0    = cyc;
    base  = pulses[0];
    to(386);
    rst[0] = 1'b0;
    to(387);
    check("mrst_valid",  {31'd0, valid_v[0]},  32'd0);
    check("mrst_out",    so_v[0],              32'd0);
    check("mrst_active", {31'd0, active_v[0]}, 32'd0);
    check("mrst_bclk",   {31'd0, bclk_v[0]},   32'd0);
    to(388);
    check("mrst_valid_lsb", {31'd0, valid_v[0]}, 32'd0);
    to(400);
    check("mrst_nopulse", pulses[0] - base, 0);
    en[0]  = 1'b0;
    rst[0] = 1'b1;
    idle(3);
    check("mrst_idle_out", so_v[0], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S master receiver for the tuner's MEMS microphone: generates the bit clock (`bclk`) and word select (`ws`) from the 48 MHz system clock, and deserializes the mic's serial data (`sd`).
- Delivers one 32-bit sample per I2S frame as `sample_out` with a one-cycle `sample_valid` pulse.
- This is the producer side of the `sample_in`/`sample_valid` interface consumed by the FFT input buffer.
- A warm-up period discards the mic's start-up frames.

Parameters:
- CLK_DIV, 8: `clk` cycles per `bclk` half-period (must be ≥2). Frame = 128*CLK_DIV `clk` cycles; default gives 46.875 kHz at 48 MHz.
- STARTUP_FRAMES, 4: complete frames discarded after `enable` before samples are emitted (0 allowed).
- CHANNEL, 0: slot captured; 0 = left (`ws` low), 1 = right (`ws` high).

Ports:
- clk  in  1  48 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- sd  in  1  serial data from mic.
- bclk  out  1  I2S bit clock, registered.
- ws  out  1  I2S word select, registered.
- sample_out  out  32  last captured word, MSB first on the wire.
- sample_valid  out  1  one-cycle pulse; `sample_out` updated at the same edge.
- active  out  1  high in RUN state.

Behaviour:
- **Reset** (`reset`==0 at a `clk` edge):
  - state=IDLE; `bclk`, `ws`, `sample_out`, `sample_valid`, `active` = 0.
  - div_cnt, bit_cnt, frame_cnt, shift register, word_ok = 0.
  - Reset mid-operation aborts immediately; no partial word is emitted.
- **States:** IDLE, WARMUP, RUN.
  - IDLE: `bclk`=0, `ws`=0, counters held at 0.
  - IDLE→WARMUP when `enable`=1, or IDLE→RUN if STARTUP_FRAMES=0. Call this edge t=0.
  - WARMUP→RUN at the `bclk` falling edge where bit_cnt wraps 63→0 and frame_cnt==STARTUP_FRAMES-1.
  - Any state→IDLE at the next edge when `enable`=0: `bclk`/`ws` forced 0, partial word discarded, no pulse.
- **Clocking** (WARMUP/RUN):
  - div_cnt counts 0..CLK_DIV-1. At div_cnt==CLK_DIV-1, `bclk` toggles and div_cnt←0.
  - First `bclk` rise occurs at t=CLK_DIV; `bclk` period is 2*CLK_DIV.
- **Falling-edge actions** (edge where `bclk` goes 1→0):
  - `sd` is sampled for bit index bit_cnt.
  - bit_cnt←(bit_cnt+1) mod 64.
  - `ws`←1 when the new bit_cnt ≥32, else 0. So `ws` rises at t=64*CLK_DIV within frame 0, i.e. 32 `bclk` periods low, then 32 high.
  - The `sd` sample is taken at the end of the `bclk` high phase, which satisfies rising-edge I2S timing; the mic updates `sd` after the falling edge.
- **Capture window** (one-bit I2S delay):
  - CHANNEL=0: bit_cnt 1..32.
  - CHANNEL=1: bit_cnt 33..63, then 0 of the next frame (wraps the frame boundary).
  - Window index w = (bit_cnt − 1 − 32*CHANNEL) mod 64; capture when w<32; w=0 is the MSB.
  - At w=0: word_ok←(state==RUN).
  - At w=31: `sample_out`←{shift[30:0], sd}, and `sample_valid`=1 for exactly one cycle iff word_ok && state==RUN. The shift register still updates in WARMUP.
- **Timing and latency:**
  - LSB capture edge in frame f: t=128*CLK_DIV*f + 66*CLK_DIV for CHANNEL=0; t=128*CLK_DIV*(f+1) + 2*CLK_DIV for CHANNEL=1. `sample_valid` is high in the cycle after that edge; there is no extra latency.
  - `sample_out` holds its value between pulses.
  - The first RUN word for CHANNEL=1 straddles the WARMUP→RUN boundary; word_ok suppresses it.
- **active:** equals (state==RUN).
- **Arithmetic:** bit_cnt is 6-bit, naturally wrapping. frame_cnt saturates at STARTUP_FRAMES. No width truncation occurs; the full 32-bit slot is passed through, and the 24-bit mic data is left-justified as delivered.

Test Plan:
- **Reset:** hold `reset`=0 for 5 cycles with `enable`=1 and `sd`=1 → all outputs 0, state IDLE. Release with `enable`=0 → outputs stay 0.
- **Left capture** (CLK_DIV=2, STARTUP_FRAMES=1, CHANNEL=0): mic model drives left=0xA5A55A5A, right=0x12345678 → `bclk` period 4 clk; `ws` rises at t=128 and falls at t=256. First `sample_valid` follows edge t=388 with `sample_out`=0xA5A55A5A; next pulse follows t=644; no pulse before t=388.
- **Right capture** (CHANNEL=1, same stimulus) → first valid word is 0x12345678, pulse after t=516. The straddling word ending at t=260 is suppressed.
- **Warm-up disabled** (STARTUP_FRAMES=0, CHANNEL=0) → `active`=1 after t=0; first pulse after t=132.
- **Enable dropped mid-slot** (at t=300) → next cycle `bclk`=0, `ws`=0, `active`=0, no pulse, `sample_out` unchanged. Re-enable → full warm-up repeats, and the first pulse occurs 388 cycles after the new t=0.
- **Mid-operation reset** (`reset`=0 at t=387, one cycle before the LSB edge) → no `sample_valid`, `sample_out`=0, IDLE.
